// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencing, divider handshake with timeout, PC redirect and stall counter
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          DIV_TIMEOUT = 40,
  parameter int          CNT_W       = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             stallreq_id,
  input  logic             stallreq_exe,
  input  logic             div_ready,
  input  logic             exc_valid,
  input  logic             exc_eret,
  input  logic [31:0]      cp0_epc,
  output logic [4:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             div_start,
  output logic             div_abort,
  output logic             div_timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TW = $clog2(DIV_TIMEOUT + 1);
  typedef enum logic {RUN, DIV} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic err_q, tmo;
  assign tmo = tcnt_q == TW'(DIV_TIMEOUT - 1);
  assign stall_cnt = cnt_q;
  assign div_timeout_err = err_q;
  // state register; reset always lands in RUN without an abort pulse
  always_ff @(posedge cpu_clk_50M)
    state_q <= cpu_rst ? RUN : state_d;
  // next state: enter DIV on an accepted divide, leave on exception, result or timeout
  always_comb
    state_d = (state_q == RUN) ? ((!exc_valid && stallreq_exe) ? DIV : RUN)
                               : ((exc_valid || div_ready || tmo) ? RUN : DIV);
  // outputs: exception outranks divider events, which outrank stall requests
  always_comb begin
    flush     = !cpu_rst && exc_valid;
    new_pc    = flush ? (exc_eret ? cp0_epc : EXC_VECTOR) : '0;
    div_start = !cpu_rst && state_q == RUN && !exc_valid && stallreq_exe;
    div_abort = !cpu_rst && state_q == DIV && (exc_valid || (!div_ready && tmo));
    stall     = (cpu_rst || exc_valid) ? 5'b00000
              : (state_q == RUN) ? (stallreq_exe ? 5'b00111 : stallreq_id ? 5'b00011 : 5'b00000)
              : ((div_ready || tmo) ? 5'b00000 : 5'b00111);
  end
  // timeout counter restarts on each DIV entry and advances while still waiting
  always_comb
    tcnt_d = div_start ? '0 : (state_q == DIV && stall != 5'b00000) ? tcnt_q + 1'b1 : tcnt_q;
  // saturating stall counter and sticky timeout flag
  always_ff @(posedge cpu_clk_50M)
    if (cpu_rst) begin
      tcnt_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      if (stall != 5'b00000 && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      if (div_abort && !exc_valid) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table and scripted sequences checked through an expected-result queue
module tb_pipe_ctrl;
  localparam logic [31:0] EV = 32'hBFC0_0380;
  logic clk = 1'b0;
  logic rst, id, exe, rdy, exc, eret;
  logic [31:0] epc;
  logic [4:0] stall, stall_s;
  logic flush, flush_s, start, start_s, abort, abort_s, err, err_s;
  logic [31:0] npc, npc_s, cnt;
  logic [3:0] cnt_s;
  typedef struct {
    string name;
    logic rst, id, exe, rdy, exc, eret;
    logic [31:0] epc;
    logic [4:0] stall;
    logic flush;
    logic [31:0] npc;
    logic start, abort, err;
    logic [31:0] cnt;
  } vec_t;
  vec_t exp_q[$];
  vec_t tbl[8];
  logic [31:0] ec;
  logic e_err;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .stallreq_id(id), .stallreq_exe(exe),
    .div_ready(rdy), .exc_valid(exc), .exc_eret(eret), .cp0_epc(epc),
    .stall(stall), .flush(flush), .new_pc(npc), .div_start(start),
    .div_abort(abort), .div_timeout_err(err), .stall_cnt(cnt)
  );
  pipe_ctrl #(.CNT_W(4)) u_sat (
    .cpu_clk_50M(clk), .cpu_rst(rst), .stallreq_id(id), .stallreq_exe(exe),
    .div_ready(rdy), .exc_valid(exc), .exc_eret(eret), .cp0_epc(epc),
    .stall(stall_s), .flush(flush_s), .new_pc(npc_s), .div_start(start_s),
    .div_abort(abort_s), .div_timeout_err(err_s), .stall_cnt(cnt_s)
  );

  function automatic vec_t mk(string n, logic r, logic i, logic x, logic d, logic e, logic t,
                              logic [31:0] p, logic [4:0] s, logic f, logic [31:0] np,
                              logic st, logic ab);
    vec_t v;
    v.name = n; v.rst = r; v.id = i; v.exe = x; v.rdy = d; v.exc = e; v.eret = t; v.epc = p;
    v.stall = s; v.flush = f; v.npc = np; v.start = st; v.abort = ab; v.err = 1'b0; v.cnt = '0;
    return v;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; id = v.id; exe = v.exe; rdy = v.rdy; exc = v.exc; eret = v.eret; epc = v.epc;
    v.cnt = ec;
    v.err = e_err;
    exp_q.push_back(v);
    ec = v.rst ? 32'd0 : (v.stall != 5'b0 ? ec + 1 : ec);
    if (v.rst) e_err = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (stall !== e.stall || flush !== e.flush || npc !== e.npc || start !== e.start ||
        abort !== e.abort || err !== e.err || cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL %s: got stall=%b flush=%b new_pc=%h start=%b abort=%b err=%b cnt=%0d, expected stall=%b flush=%b new_pc=%h start=%b abort=%b err=%b cnt=%0d",
               e.name, stall, flush, npc, start, abort, err, cnt,
               e.stall, e.flush, e.npc, e.start, e.abort, e.err, e.cnt);
    end
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, got, want);
    end
  endtask

  task automatic div_entry();
    step(mk("div_start", 0, 0, 1, 0, 0, 0, 0, 5'b00111, 0, 0, 1, 0));
  endtask

  task automatic div_wait(input int n);
    for (int i = 0; i < n; i++)
      step(mk("div_wait", 0, i[0], 1, 0, 0, 0, 0, 5'b00111, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1; id = 0; exe = 0; rdy = 0; exc = 0; eret = 0; epc = '0;
    ec = '0; e_err = 1'b0;
    repeat (2) @(posedge clk);
    tbl[0] = mk("rst_all",   1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 5'b00000, 0, 0, 0, 0);
    tbl[1] = mk("idle",      0, 0, 0, 0, 0, 0, 0,             5'b00000, 0, 0, 0, 0);
    tbl[2] = mk("load_use",  0, 1, 0, 0, 0, 0, 0,             5'b00011, 0, 0, 0, 0);
    tbl[3] = mk("idle_lu",   0, 0, 0, 0, 0, 0, 0,             5'b00000, 0, 0, 0, 0);
    tbl[4] = mk("eret_exe",  0, 1, 1, 0, 1, 1, 32'h8000_1234, 5'b00000, 1, 32'h8000_1234, 0, 0);
    tbl[5] = mk("run_id",    0, 1, 0, 0, 0, 0, 0,             5'b00011, 0, 0, 0, 0);
    tbl[6] = mk("exc_run",   0, 0, 0, 0, 1, 0, 32'h1234,      5'b00000, 1, EV, 0, 0);
    tbl[7] = mk("rdy_run",   0, 0, 0, 1, 0, 0, 0,             5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(tbl[i]);
    // divide with result on the 32nd cycle after start
    div_entry();
    div_wait(31);
    step(mk("div_ready", 0, 0, 1, 1, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    step(mk("after_div", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    // exception on DIV cycle 5
    div_entry();
    div_wait(4);
    step(mk("div_exc", 0, 1, 1, 0, 1, 0, 32'h1111_2222, 5'b00000, 1, EV, 0, 1));
    step(mk("run_after_exc", 0, 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 0));
    // timeout on the 40th DIV cycle, then a normal restart
    div_entry();
    div_wait(39);
    step(mk("div_tmo", 0, 0, 1, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 1));
    e_err = 1'b1;
    div_entry();
    // reset on DIV cycle 10 of the restarted divide
    div_wait(9);
    step(mk("rst_div", 1, 0, 1, 1, 1, 0, 32'h5, 5'b00000, 0, 0, 0, 0));
    step(mk("post_rst", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    // 20 stalled cycles saturate a 4-bit counter
    for (int i = 0; i < 20; i++)
      step(mk("sat_id", 0, 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 0));
    step(mk("sat_idle", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 0));
    chk("sat_cnt4", {28'd0, cnt_s}, 32'd15);
    chk("sat_err4", {31'd0, err_s}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage MIPS core. It generates the per-stage stall vector and the global flush that the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers consume. It sequences the multi-cycle divider through a start/ready handshake with a timeout, and redirects the PC on exceptions and ERET. It also keeps a saturating stall-cycle performance counter.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, PC loaded on any exception other than ERET.
DIV_TIMEOUT, 40, maximum DIV-state cycles before the divider is aborted.
CNT_W, 32, width of the stall performance counter.

Ports:
cpu_clk_50M  input  1  core clock, all state on its rising edge
cpu_rst  input  1  synchronous reset, active-high
stallreq_id  input  1  load-use hazard detected in ID
stallreq_exe  input  1  divide instruction in EXE needs the divider
div_ready  input  1  divider result valid (single-cycle pulse)
exc_valid  input  1  exception committed in MEM
exc_eret  input  1  qualifies exc_valid as ERET
cp0_epc  input  32  EPC value from CP0
stall  output  5  hold enables: [0]=PC, [1]=IF/ID, [2]=ID/EXE, [3]=EXE/MEM, [4]=MEM/WB
flush  output  1  clears all pipeline registers at the next edge
new_pc  output  32  redirect target, valid only while flush=1
div_start  output  1  one-cycle divider start pulse
div_abort  output  1  one-cycle divider cancel pulse
div_timeout_err  output  1  sticky flag, set on a divider timeout
stall_cnt  output  CNT_W  count of cycles with stall!=0, saturating

Behaviour:
- Reset (cpu_rst=1 at an edge):
  - state=RUN, timeout counter=0, stall_cnt=0, div_timeout_err=0.
  - While cpu_rst=1: all combinational outputs are 0 (stall, flush, new_pc, div_start, div_abort).
  - Reset mid-DIV returns the block to RUN with no div_abort pulse; the divider is reset separately.
- States: RUN, DIV. stall, flush, new_pc, div_start and div_abort are combinational from the state and the inputs (zero latency). Counters and the state register update at the edge.
- Priority within a cycle: exc_valid > div_ready/timeout > stallreq_exe > stallreq_id.
- RUN:
  - exc_valid=1: flush=1, stall=0, new_pc = exc_eret ? cp0_epc : EXC_VECTOR. Stay in RUN; all stall requests that cycle are ignored.
  - Else stallreq_exe=1: div_start=1, stall=5'b00111, timeout counter cleared, next state DIV.
  - Else stallreq_id=1: stall=5'b00011 (a bubble enters ID/EXE).
  - Else stall=0.
- DIV:
  - exc_valid=1: flush=1, div_abort=1, stall=0, new_pc as above, next state RUN.
  - Else div_ready=1: stall=0, next state RUN. A new stallreq_exe is only accepted from the following RUN cycle.
  - Else timeout counter == DIV_TIMEOUT-1: div_abort=1, div_timeout_err set, stall=0, next state RUN.
  - Else stall=5'b00111 and the timeout counter increments. stallreq_id is ignored because the stall already covers it.
- div_start is asserted for exactly one cycle per DIV entry; it is never asserted in DIV.
- div_timeout_err clears only on reset.
- stall_cnt increments on every non-reset cycle with stall!=0. It holds at 2^CNT_W-1 and never wraps.
- flush and stall are never both nonzero in the same cycle.
- new_pc=0 whenever flush=0.

Test Plan:
- Load-use: stallreq_id=1 for 1 cycle in RUN -> stall=00011 that cycle; stall_cnt increments by 1; no div_start.
- Divide:
  - Stimulus: stallreq_exe=1 in RUN; div_ready pulses 32 cycles after div_start.
  - Required response: div_start=1 for exactly 1 cycle; stall=00111 on that cycle and the next 31 DIV cycles; stall=0 on the div_ready cycle; state returns to RUN; stall_cnt=32.
- Exception during DIV:
  - Stimulus: exc_valid=1, exc_eret=0 on DIV cycle 5.
  - Required response: flush=1, div_abort=1, new_pc=32'hBFC00380, stall=0; next cycle is RUN.
- ERET in RUN with stallreq_exe=1 in the same cycle: cp0_epc=32'h8000_1234 -> flush=1, new_pc=32'h80001234, div_start=0, remains in RUN.
- Timeout: DIV_TIMEOUT=40, div_ready never asserted -> div_abort=1 on the 40th DIV cycle; div_timeout_err=1 and stays 1; the next stallreq_exe starts normally.
- Reset mid-DIV and saturation:
  - cpu_rst=1 on DIV cycle 10 -> next cycle state=RUN, all outputs 0, stall_cnt=0.
  - Separately, with CNT_W=4 and 20 stalled cycles -> stall_cnt=15.
